// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-side bus bundle between the fetch queue, instruction memory, execute and decode.
//   fetch_en                   : fetch permission
//   imem_a / imem_rd           : instruction memory address out, combinational read data in
//   redirect_valid/redirect_pc : one-cycle PC redirect from execute
//   out_valid/out_ready        : decode handshake carrying out_instr/out_pc
//   misalign_err               : sticky misaligned-redirect flag
//   master = fetch queue, slave = its environment
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_a;
    logic [DATA_W-1:0] imem_rd;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              misalign_err;

    modport master (
        input  fetch_en, imem_rd, redirect_valid, redirect_pc, out_ready,
        output imem_a, out_valid, out_instr, out_pc, misalign_err
    );

    modport slave (
        output fetch_en, imem_rd, redirect_valid, redirect_pc, out_ready,
        input  imem_a, out_valid, out_instr, out_pc, misalign_err
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches instruction words and presents {pc, instr} pairs to decode through a small queue.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_queue_if master (memory port, redirect input, decode handshake, misalign flag)
module instr_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic              misalign;
    logic              pop, push;

    assign pop  = bus.out_valid & bus.out_ready;
    // a full queue still accepts a new word when the head leaves in the same cycle
    assign push = bus.fetch_en & ~bus.redirect_valid & ((count < FULL) | pop);

    assign bus.imem_a       = fetch_pc;
    assign bus.out_valid    = count != '0;
    assign bus.out_instr    = instr_q[rd_ptr];
    assign bus.out_pc       = pc_q[rd_ptr];
    assign bus.misalign_err = misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // flush: any same-cycle push or pop is dropped
            fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (|bus.redirect_pc[1:0])
                misalign <= 1'b1;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= bus.imem_rd;
                wr_ptr          <= wr_ptr + PW'(1);
                fetch_pc        <= fetch_pc + ADDR_W'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random checks of instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [63:0] model_q [$];
    logic [31:0] model_pc;
    logic        model_mis;

    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.imem_rd = mem(bus.imem_a);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_pc  = 32'h0000_0000;
        model_mis = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, model_q.size() != 0});
        if (model_q.size() != 0) begin
            chk("out_pc", {32'd0, bus.out_pc}, {32'd0, model_q[0][63:32]});
            chk("out_instr", {32'd0, bus.out_instr}, {32'd0, model_q[0][31:0]});
        end
        chk("imem_a", {32'd0, bus.imem_a}, {32'd0, model_pc});
        chk("misalign_err", {63'd0, bus.misalign_err}, {63'd0, model_mis});
    endtask

    // one clock: drive inputs, advance the model by the rules, check after the edge
    task automatic step(input logic en, input logic rdy, input logic rv, input logic [31:0] rp);
        logic pop, push;
        bus.fetch_en       = en;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        pop  = (model_q.size() != 0) && rdy;
        push = en && !rv && ((model_q.size() < DEPTH) || pop);
        @(posedge clk);
        if (rv) begin
            model_q.delete();
            model_pc = {rp[31:2], 2'b00};
            if (rp[1:0] != 2'b00) model_mis = 1'b1;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back({model_pc, mem(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_pc", {32'd0, bus.out_pc}, 64'd0);
        chk("rst_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("rst_imem_a", {32'd0, bus.imem_a}, 64'd0);
        chk("rst_misalign", {63'd0, bus.misalign_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.fetch_en       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();
        #2;
        chk("reset_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_pc", {32'd0, bus.out_pc}, 64'd0);
        chk("reset_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("reset_imem_a", {32'd0, bus.imem_a}, 64'd0);
        #5 rst_n = 1'b1;

        // streaming from reset
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        // backpressure fills the queue and stalls the fetch address
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        // aligned redirect on a full queue
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        // misaligned redirect makes the flag sticky
        step(1'b1, 1'b1, 1'b1, 32'h0000_0042);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        // redirect with fetch disabled, then back-to-back redirects
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        // address wrap
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        // async reset with two entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        async_reset_check();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rp;
            rp = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : ($urandom & 32'h0000_0FFC);
            if ($urandom % 10 == 0) rp[1:0] = 2'($urandom);
            step(($urandom % 6) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0, rp);
            if (i == 300) async_reset_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
